// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sign-magnitude Q7.8 multiplier
package mult_pkg;

  typedef enum logic [1:0] {IDLE, MUL, SHIFT, DONE} state_t;

  localparam int MAG_W     = 15;
  localparam int PROD_W    = 32;
  localparam int MUL_ITER  = 15;
  localparam int FRAC_BITS = 8;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/shift_add_core.sv
// rtl/shift_add_core.sv - radix-2 shift-add datapath: accumulator, operand shifters, iteration count
module shift_add_core
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [MAG_W-1:0]  a_mag,
  input  logic [MAG_W-1:0]  b_mag,
  output logic [PROD_W-1:0] acc,
  output logic              last
);

  logic [PROD_W-1:0] mcand;
  logic [MAG_W-1:0]  mplier;
  logic [CNT_W-1:0]  count;

  // load clears the accumulator and latches operands; each step consumes one multiplier bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= PROD_W'(a_mag);
      mplier <= b_mag;
      count  <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  // high while the final multiplier bit is being consumed
  assign last = (count == CNT_W'(MUL_ITER - 1));

endmodule

// File: rtl/seq_sm_multiplier.sv
// rtl/seq_sm_multiplier.sv - sequential sign-magnitude Q7.8 multiplier with post-shift and overflow flags
module seq_sm_multiplier
  import mult_pkg::*;
#(
  parameter int SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        a,
  input  logic [15:0]        b,
  input  logic [SHIFT_W-1:0] shamt,
  output logic               ready,
  output logic               done,
  output logic [31:0]        result,
  output logic [7:0]         signedResult,
  output logic               sign,
  output logic               overflowHigh,
  output logic               overflowShift
);

  state_t             state;
  state_t             next_state;
  logic               load;
  logic               step;
  logic               last;
  logic [PROD_W-1:0]  acc;
  logic [SHIFT_W-1:0] shamt_q;
  logic               sign_q;

  logic [2*PROD_W-1:0] wide;
  logic [PROD_W-1:0]   shifted;
  logic [PROD_W-1:0]   lost;
  logic [7:0]          int_byte;

  shift_add_core u_core (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .a_mag (a[MAG_W-1:0]),
    .b_mag (b[MAG_W-1:0]),
    .acc   (acc),
    .last  (last)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state and datapath control
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = MUL;
        end
      end
      MUL: begin
        step = 1'b1;
        if (last) begin
          next_state = SHIFT;
        end
      end
      SHIFT:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // per-request operand attributes captured on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shamt_q <= '0;
      sign_q  <= 1'b0;
    end else if (load) begin
      shamt_q <= shamt;
      sign_q  <= a[15] ^ b[15];
    end
  end

  // widen before shifting so bits pushed past bit 31 stay visible for the overflow flag
  always_comb begin
    wide     = {{PROD_W{1'b0}}, acc} << shamt_q;
    shifted  = wide[PROD_W-1:0];
    lost     = wide[2*PROD_W-1:PROD_W];
    int_byte = shifted[2*FRAC_BITS +: 8];
  end

  // registered outputs, refreshed only in SHIFT and held until the next product
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result        <= '0;
      signedResult  <= '0;
      sign          <= 1'b0;
      overflowHigh  <= 1'b0;
      overflowShift <= 1'b0;
    end else if (state == SHIFT) begin
      result        <= shifted;
      signedResult  <= ~int_byte + 8'd1;
      sign          <= sign_q & (|shifted);
      overflowHigh  <= |shifted[PROD_W-1:2*FRAC_BITS+7];
      overflowShift <= |lost;
    end
  end

  // done pulses in the idle cycle following DONE so a new start can overlap it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= (state == DONE);
    end
  end

  assign ready = (state == IDLE);

endmodule

// File: tb/tb_seq_sm_multiplier.sv
// tb/tb_seq_sm_multiplier.sv - self-checking bench for seq_sm_multiplier
module tb_seq_sm_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  shamt;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic [7:0]  signedResult;
  logic        sign;
  logic        overflowHigh;
  logic        overflowShift;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  sh;
    logic [31:0] res;
    logic        sgn;
    logic [7:0]  sr;
    logic        oh;
    logic        os;
  } vec_t;

  vec_t vecs[7];

  seq_sm_multiplier #(.SHIFT_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .a             (a),
    .b             (b),
    .shamt         (shamt),
    .ready         (ready),
    .done          (done),
    .result        (result),
    .signedResult  (signedResult),
    .sign          (sign),
    .overflowHigh  (overflowHigh),
    .overflowShift (overflowShift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: plain integer product of magnitudes, then scaled by 2**shamt
  function automatic vec_t model(input logic [15:0] ia, input logic [15:0] ib, input logic [2:0] sh);
    vec_t v;
    longint unsigned p;
    longint unsigned full;
    int ib_byte;
    p    = longint'(ia[14:0]) * longint'(ib[14:0]);
    full = p * (longint'(1) << sh);
    v.a   = ia;
    v.b   = ib;
    v.sh  = sh;
    v.res = full[31:0];
    v.os  = (full >= 64'h1_0000_0000);
    v.oh  = (v.res >= 32'h0080_0000);
    ib_byte = int'((v.res / 32'h1_0000) % 256);
    v.sr  = 8'((256 - ib_byte) % 256);
    v.sgn = (ia[15] != ib[15]) && (v.res != 0);
    return v;
  endfunction

  // runs one operation; noise pulses start with junk operands while busy
  task automatic run_op(input vec_t v, input string tag, input bit noise);
    int lat;
    int n;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " ready_before_start"}, 32'(ready), 32'd1);
    a = v.a; b = v.b; shamt = v.sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " ready_low_after_accept"}, 32'(ready), 32'd0);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (noise && i < 12) begin
        start = 1'b1; a = 16'($urandom); b = 16'($urandom); shamt = 3'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'd17);
    chk({tag, " result"}, result, v.res);
    chk({tag, " sign"}, 32'(sign), 32'(v.sgn));
    chk({tag, " signedResult"}, 32'(signedResult), 32'(v.sr));
    chk({tag, " overflowHigh"}, 32'(overflowHigh), 32'(v.oh));
    chk({tag, " overflowShift"}, 32'(overflowShift), 32'(v.os));
    chk({tag, " ready_with_done"}, 32'(ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    tests_run    = 0;
    tests_failed = 0;
    start = 1'b0; a = '0; b = '0; shamt = '0;

    vecs[0] = '{16'h0100, 16'h0100, 3'd0, 32'h00010000, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[1] = '{16'h8280, 16'h0300, 3'd0, 32'h00078000, 1'b1, 8'hF9, 1'b0, 1'b0};
    vecs[2] = '{16'h6400, 16'h0200, 3'd0, 32'h00C80000, 1'b0, 8'h38, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 3'd3, 32'hFFF80008, 1'b0, 8'h08, 1'b1, 1'b1};
    vecs[4] = '{16'h7FFF, 16'h7FFF, 3'd2, 32'hFFFC0004, 1'b0, 8'h04, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8100, 3'd0, 32'h00000000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{16'h8180, 16'h8040, 3'd1, 32'h0000C000, 1'b0, 8'h00, 1'b0, 1'b0};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset flags", {28'd0, sign, overflowHigh, overflowShift, 1'b0}, 32'd0);
    chk("reset signedResult", 32'(signedResult), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // directed table; calls are back-to-back so each start lands in the done cycle
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i), 1'b0);
    end

    // done is a single pulse and outputs hold afterwards
    @(posedge clk); #1;
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("hold_result", result, vecs[6].res);

    // start pulses while busy are ignored
    run_op(vecs[1], "noise", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("noise_no_queue", 32'(ready), 32'd1);
    chk("noise_hold", result, vecs[1].res);

    // asynchronous reset in the middle of MUL
    a = vecs[3].a; b = vecs[3].b; shamt = vecs[3].sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset ready", 32'(ready), 32'd1);
    chk("midreset result", result, 32'd0);
    chk("midreset signedResult", 32'(signedResult), 32'd0);
    chk("midreset flags", {29'd0, sign, overflowHigh, overflowShift}, 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(vecs[2], "after_reset", 1'b0);

    // randomized operands against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 10 == 3) ra[14:0] = '0;
      if (i % 10 == 7) rb[14:0] = 15'h7FFF;
      v = model(ra, rb, 3'($urandom));
      run_op(v, $sformatf("rand%0d", i), (i % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
